// File: rtl/fp_flag_acc.sv
// fp_flag_acc: per-lane IEEE-754 status generation, PIPE-deep status pipeline, sticky fflags with CSR write.
// Status PIPE cycles after in_valid, fflags one cycle later; no backpressure. Trap pulse under FP_FLAG_TRAP_EN.
module fp_flag_acc #(
   parameter int LANES = 4,
   parameter int PIPE  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [LANES-1:0]   in_valid,
   input  logic [LANES-1:0]   a_is_nan,
   input  logic [LANES-1:0]   b_is_nan,
   input  logic [LANES-1:0]   a_is_q,
   input  logic [LANES-1:0]   b_is_q,
   input  logic [LANES-1:0]   r_is_0nan,
   input  logic [LANES-1:0]   div_zero,
   input  logic [LANES-1:0]   overflow,
   input  logic [LANES-1:0]   underflow,
   input  logic [LANES-1:0]   inexact_rnd,
   input  logic [LANES-1:0]   inexact_sft,
   input  logic               flush,
   input  logic               csr_wr,
   input  logic [4:0]         csr_wdata,
`ifdef FP_FLAG_TRAP_EN
   input  logic [4:0]         trap_en,
`endif
   output logic [LANES-1:0]   out_valid,
   output logic [5*LANES-1:0] status,
   output logic [4:0]         fflags
`ifdef FP_FLAG_TRAP_EN
   ,
   output logic               trap
`endif
);

   logic [LANES-1:0][4:0] raw_st;
   logic [LANES-1:0]      pipe_vld;
   logic [LANES-1:0][4:0] pipe_st;
   logic [LANES-1:0][4:0] out_st;
   logic [4:0]            retire_or;
   logic [4:0]            fflags_d, fflags_q;

   // Quiet-NaN propagation is deliberately excluded from NV; overflow always implies NX.
   always_comb begin
      raw_st = '0;
      for (int i = 0; i < LANES; i++) begin
         if (in_valid[i]) begin
            raw_st[i][4] = (a_is_nan[i] & ~a_is_q[i]) | (b_is_nan[i] & ~b_is_q[i]) | r_is_0nan[i];
            raw_st[i][3] = div_zero[i];
            raw_st[i][2] = overflow[i];
            raw_st[i][1] = underflow[i];
            raw_st[i][0] = inexact_rnd[i] | inexact_sft[i] | overflow[i];
         end
      end
   end

   generate
      if (PIPE == 0) begin : g_comb
         assign pipe_vld = in_valid;
         assign pipe_st  = raw_st;
      end else begin : g_pipe
         logic [LANES-1:0]      vld_d [PIPE];
         logic [LANES-1:0]      vld_q [PIPE];
         logic [LANES-1:0][4:0] st_d  [PIPE];
         logic [LANES-1:0][4:0] st_q  [PIPE];

         always_comb begin
            vld_d[0] = flush ? '0 : in_valid;
            st_d[0]  = raw_st;
            for (int s = 1; s < PIPE; s++) begin
               vld_d[s] = flush ? '0 : vld_q[s-1];
               st_d[s]  = st_q[s-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int s = 0; s < PIPE; s++) vld_q[s] <= '0;
            end else begin
               vld_q <= vld_d;
            end
         end

         // Status is qualified by valid at the output, so the data stages need no reset.
         always_ff @(posedge clk) begin
            st_q <= st_d;
         end

         assign pipe_vld = vld_q[PIPE-1];
         assign pipe_st  = st_q[PIPE-1];
      end
   endgenerate

   always_comb begin
      out_st    = '0;
      retire_or = '0;
      for (int i = 0; i < LANES; i++) begin
         if (pipe_vld[i]) begin
            out_st[i] = pipe_st[i];
            retire_or = retire_or | pipe_st[i];
         end
      end
   end

   assign out_valid = pipe_vld;
   assign status    = out_st;

   // Retiring flags are ORed after the software write so a same-cycle write cannot drop them.
   always_comb begin
      fflags_d = (csr_wr ? csr_wdata : fflags_q) | retire_or;
   end

   always_ff @(posedge clk) begin
      if (rst) fflags_q <= '0;
      else     fflags_q <= fflags_d;
   end

   assign fflags = fflags_q;

`ifdef FP_FLAG_TRAP_EN
   logic trap_d, trap_q;

   always_comb begin
      trap_d = |(trap_en & retire_or);
   end

   always_ff @(posedge clk) begin
      if (rst) trap_q <= 1'b0;
      else     trap_q <= trap_d;
   end

   assign trap = trap_q;
`endif

endmodule

// File: tb/tb_fp_flag_acc.sv
// Bench for fp_flag_acc: PIPE=1 and PIPE=2 instances share stimulus; queued expectations checked on output.
module tb_fp_flag_acc;

   typedef struct packed {
      logic [3:0]  vld;
      logic [19:0] st;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid, a_is_nan, b_is_nan, a_is_q, b_is_q, r_is_0nan;
   logic [3:0]  div_zero, overflow, underflow, inexact_rnd, inexact_sft;
   logic        flush, csr_wr;
   logic [4:0]  csr_wdata;
   logic [3:0]  o1_valid, o2_valid;
   logic [19:0] o1_status, o2_status;
   logic [4:0]  o1_fflags, o2_fflags;
`ifdef FP_FLAG_TRAP_EN
   logic [4:0]  trap_en;
   logic        trap1, trap2;
`endif

   int   chk  = 0;
   int   pass = 0;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   fp_flag_acc #(.LANES(4), .PIPE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a_is_nan(a_is_nan), .b_is_nan(b_is_nan),
      .a_is_q(a_is_q), .b_is_q(b_is_q), .r_is_0nan(r_is_0nan), .div_zero(div_zero),
      .overflow(overflow), .underflow(underflow), .inexact_rnd(inexact_rnd),
      .inexact_sft(inexact_sft), .flush(flush), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
`ifdef FP_FLAG_TRAP_EN
      .trap_en(trap_en), .trap(trap1),
`endif
      .out_valid(o1_valid), .status(o1_status), .fflags(o1_fflags)
   );

   fp_flag_acc #(.LANES(4), .PIPE(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a_is_nan(a_is_nan), .b_is_nan(b_is_nan),
      .a_is_q(a_is_q), .b_is_q(b_is_q), .r_is_0nan(r_is_0nan), .div_zero(div_zero),
      .overflow(overflow), .underflow(underflow), .inexact_rnd(inexact_rnd),
      .inexact_sft(inexact_sft), .flush(flush), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
`ifdef FP_FLAG_TRAP_EN
      .trap_en(trap_en), .trap(trap2),
`endif
      .out_valid(o2_valid), .status(o2_status), .fflags(o2_fflags)
   );

   function automatic logic [4:0] model_lane(int i);
      logic [4:0] s;
      s[4] = (a_is_nan[i] & ~a_is_q[i]) | (b_is_nan[i] & ~b_is_q[i]) | r_is_0nan[i];
      s[3] = div_zero[i];
      s[2] = overflow[i];
      s[1] = underflow[i];
      s[0] = inexact_rnd[i] | inexact_sft[i] | overflow[i];
      return in_valid[i] ? s : 5'b0;
   endfunction

   function automatic exp_t model_cycle();
      exp_t e;
      e = '0;
      e.vld = in_valid;
      for (int i = 0; i < 4; i++) e.st[5*i +: 5] = model_lane(i);
      return e;
   endfunction

   function automatic logic [4:0] or_lanes(logic [19:0] s);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r = r | s[5*i +: 5];
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = '0; a_is_nan = '0; b_is_nan = '0; a_is_q = '0; b_is_q = '0;
      r_is_0nan = '0; div_zero = '0; overflow = '0; underflow = '0;
      inexact_rnd = '0; inexact_sft = '0; flush = 1'b0; csr_wr = 1'b0; csr_wdata = '0;
`ifdef FP_FLAG_TRAP_EN
      trap_en = '0;
`endif
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      q1.delete();
      q2.delete();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      chk++; if (o1_valid !== 4'b0) $display("FAIL reset_valid1: got %b want 0000", o1_valid); else pass++;
      chk++; if (o1_status !== 20'b0) $display("FAIL reset_status1: got %h want 0", o1_status); else pass++;
      chk++; if (o2_valid !== 4'b0) $display("FAIL reset_valid2: got %b want 0000", o2_valid); else pass++;
      rst = 1'b0;
      tick();
      chk++; if (o1_fflags !== 5'b0) $display("FAIL reset_fflags1: got %b want 00000", o1_fflags); else pass++;
      chk++; if (o2_fflags !== 5'b0) $display("FAIL reset_fflags2: got %b want 00000", o2_fflags); else pass++;
`ifdef FP_FLAG_TRAP_EN
      chk++; if (trap1 !== 1'b0) $display("FAIL reset_trap: got %b want 0", trap1); else pass++;
`endif
   endtask

   task automatic test_snan();
      exp_t e;
      do_reset();
      in_valid = 4'b0001; a_is_nan = 4'b0001;
      q1.push_back(model_cycle());
      tick();
      clear_inputs();
      e = q1.pop_front();
      chk++; if (o1_valid !== e.vld) $display("FAIL snan_valid: got %b want %b", o1_valid, e.vld); else pass++;
      chk++; if (o1_status !== e.st) $display("FAIL snan_status: got %h want %h", o1_status, e.st); else pass++;
      chk++; if (o1_status[4:0] !== 5'b10000) $display("FAIL snan_nv: got %b want 10000", o1_status[4:0]); else pass++;
      tick();
      chk++; if (o1_fflags !== 5'b10000) $display("FAIL snan_fflags: got %b want 10000", o1_fflags); else pass++;
      chk++; if (o1_valid !== 4'b0) $display("FAIL snan_valid_drop: got %b want 0000", o1_valid); else pass++;
   endtask

   task automatic test_qnan();
      exp_t e;
      do_reset();
      in_valid = 4'b0100; a_is_nan = 4'b0100; a_is_q = 4'b0100; inexact_rnd = 4'b0100;
      q1.push_back(model_cycle());
      tick();
      clear_inputs();
      e = q1.pop_front();
      chk++; if (o1_valid !== e.vld) $display("FAIL qnan_valid: got %b want %b", o1_valid, e.vld); else pass++;
      chk++; if (o1_status[14:10] !== 5'b00001) $display("FAIL qnan_status: got %b want 00001", o1_status[14:10]); else pass++;
      tick();
      chk++; if (o1_fflags !== 5'b00001) $display("FAIL qnan_fflags: got %b want 00001", o1_fflags); else pass++;
   endtask

   task automatic test_csr_merge();
      exp_t e;
      do_reset();
      in_valid = 4'b0010; underflow = 4'b0010;
      q1.push_back(model_cycle());
      tick();
      clear_inputs();
      csr_wr = 1'b1; csr_wdata = 5'b00100;
      e = q1.pop_front();
      chk++; if (o1_status !== e.st) $display("FAIL csr_retire_status: got %h want %h", o1_status, e.st); else pass++;
      tick();
      csr_wr = 1'b1; csr_wdata = 5'b00001;
      chk++; if (o1_fflags !== 5'b00110) $display("FAIL csr_merge_fflags: got %b want 00110", o1_fflags); else pass++;
      tick();
      csr_wr = 1'b0;
      chk++; if (o1_fflags !== 5'b00001) $display("FAIL csr_overwrite: got %b want 00001", o1_fflags); else pass++;
   endtask

   task automatic test_flush_inflight();
      logic [3:0]  seen_vld;
      logic [19:0] seen_st;
      do_reset();
      in_valid = 4'b1111; overflow = 4'b1111;
      tick();
      clear_inputs();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      seen_vld = '0; seen_st = '0;
      for (int c = 0; c < 4; c++) begin
         seen_vld = seen_vld | o2_valid;
         seen_st  = seen_st | o2_status;
         tick();
      end
      chk++; if (seen_vld !== 4'b0) $display("FAIL flush_valid: got %b want 0000", seen_vld); else pass++;
      chk++; if (seen_st !== 20'b0) $display("FAIL flush_status: got %h want 0", seen_st); else pass++;
      chk++; if (o2_fflags !== 5'b0) $display("FAIL flush_fflags: got %b want 00000", o2_fflags); else pass++;
   endtask

   task automatic test_flush_retire();
      exp_t e;
      do_reset();
      in_valid = 4'b1111; overflow = 4'b1111;
      q2.push_back(model_cycle());
      tick();
      clear_inputs();
      tick();
      flush = 1'b1;
      e = q2.pop_front();
      chk++; if (o2_valid !== e.vld) $display("FAIL flushret_valid: got %b want %b", o2_valid, e.vld); else pass++;
      chk++; if (o2_status !== e.st) $display("FAIL flushret_status: got %h want %h", o2_status, e.st); else pass++;
      tick();
      flush = 1'b0;
      chk++; if (o2_fflags !== 5'b00101) $display("FAIL flushret_fflags: got %b want 00101", o2_fflags); else pass++;
      chk++; if (o2_valid !== 4'b0) $display("FAIL flushret_drop: got %b want 0000", o2_valid); else pass++;
   endtask

   task automatic test_back_to_back();
      exp_t       e;
      logic [4:0] ff1, ff2, ret1, ret2;
      do_reset();
      ff1 = '0; ff2 = '0; ret1 = '0; ret2 = '0;
      q2.push_back('0);
      for (int c = 0; c < 24; c++) begin
         if (c < 20) begin
            in_valid    = 4'($urandom);
            a_is_nan    = 4'($urandom); a_is_q = 4'($urandom);
            b_is_nan    = 4'($urandom); b_is_q = 4'($urandom);
            r_is_0nan   = 4'($urandom & $urandom);
            div_zero    = 4'($urandom & $urandom);
            overflow    = 4'($urandom & $urandom);
            underflow   = 4'($urandom & $urandom);
            inexact_rnd = 4'($urandom & $urandom);
            inexact_sft = 4'($urandom & $urandom);
            csr_wr      = ($urandom_range(0, 5) == 0);
            csr_wdata   = 5'($urandom);
         end else begin
            clear_inputs();
         end
         ff1 = (csr_wr ? csr_wdata : ff1) | ret1;
         ff2 = (csr_wr ? csr_wdata : ff2) | ret2;
         q1.push_back(model_cycle());
         q2.push_back(model_cycle());
         tick();
         chk++; if (o1_fflags !== ff1) $display("FAIL b2b_fflags1 c%0d: got %b want %b", c, o1_fflags, ff1); else pass++;
         chk++; if (o2_fflags !== ff2) $display("FAIL b2b_fflags2 c%0d: got %b want %b", c, o2_fflags, ff2); else pass++;
         e = q1.pop_front();
         chk++; if ({o1_valid, o1_status} !== {e.vld, e.st})
            $display("FAIL b2b_out1 c%0d: got %b/%h want %b/%h", c, o1_valid, o1_status, e.vld, e.st); else pass++;
         ret1 = or_lanes(e.st);
         e = q2.pop_front();
         chk++; if ({o2_valid, o2_status} !== {e.vld, e.st})
            $display("FAIL b2b_out2 c%0d: got %b/%h want %b/%h", c, o2_valid, o2_status, e.vld, e.st); else pass++;
         ret2 = or_lanes(e.st);
      end
   endtask

   task automatic test_reset_full();
      do_reset();
      csr_wr = 1'b1; csr_wdata = 5'b11111;
      tick();
      clear_inputs();
      in_valid = 4'b1111; overflow = 4'b1111;
      tick();
      tick();
      chk++; if (o1_fflags !== 5'b11111) $display("FAIL rstfull_pre_fflags: got %b want 11111", o1_fflags); else pass++;
      chk++; if (o2_valid !== 4'b1111) $display("FAIL rstfull_pre_valid: got %b want 1111", o2_valid); else pass++;
      rst = 1'b1; csr_wr = 1'b1; csr_wdata = 5'b11111;
      tick();
      chk++; if ({o1_valid, o1_status, o1_fflags} !== 29'b0)
         $display("FAIL rstfull_dut1: got %b/%h/%b want zeros", o1_valid, o1_status, o1_fflags); else pass++;
      chk++; if ({o2_valid, o2_status, o2_fflags} !== 29'b0)
         $display("FAIL rstfull_dut2: got %b/%h/%b want zeros", o2_valid, o2_status, o2_fflags); else pass++;
      rst = 1'b0;
      clear_inputs();
   endtask

`ifdef FP_FLAG_TRAP_EN
   task automatic test_trap();
      int hi;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         trap_en = (k == 0) ? 5'b00100 : 5'b10000;
         in_valid = 4'b1000; overflow = 4'b1000;
         tick();
         in_valid = '0; overflow = '0;
         tick();
         chk++; if (trap1 !== (k == 0)) $display("FAIL trap_edge k%0d: got %b want %b", k, trap1, (k == 0)); else pass++;
         hi = 0;
         for (int c = 0; c < 4; c++) begin
            if (trap1 === 1'b1) hi++;
            tick();
         end
         chk++; if (hi != ((k == 0) ? 1 : 0)) $display("FAIL trap_width k%0d: got %0d want %0d", k, hi, (k == 0) ? 1 : 0); else pass++;
      end
   endtask
`endif

   initial begin
      clear_inputs();
      rst = 1'b1;
      test_reset();
      test_snan();
      test_qnan();
      test_csr_merge();
      test_flush_inflight();
      test_flush_retire();
      test_back_to_back();
      test_reset_full();
`ifdef FP_FLAG_TRAP_EN
      test_trap();
`endif
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
